// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The package holds the op and state enums, the last iteration index and the op decode helpers.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_SIGN = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam logic [4:0] ITER_LAST = 5'd31;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of the unsigned datapath: a shift-add multiply step or a restoring divide step.
// Multiply keeps the multiplier in the low half; divide keeps the dividend and quotient bits there.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH+1:0] diff_s;

    // Compute both step candidates and select by operation
    always_comb begin
        sum_s  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & opnd};
        shl_s  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff_s = {1'b0, shl_s} - {2'b00, opnd};
        acc_nxt = acc;
        if (is_div) begin
            // The top bit of diff_s is the borrow: restore the shifted remainder when it is set
            if (diff_s[WIDTH+1]) begin
                acc_nxt = {shl_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_nxt = {sum_s, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit: FSM, iteration counter, sign fix-up and HI/LO write side.
// Operands are reduced to magnitudes at start; signs are applied once, in the SIGN cycle.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             MDU_clk,
    input  logic             MDU_rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data,
    output logic             hi_w,
    output logic             lo_w
);

    state_e             state_r, state_s;
    logic [4:0]         cnt_r;
    logic [2*WIDTH-1:0] acc_r, acc_nxt_s, res_s;
    logic [WIDTH-1:0]   opnd_r, hi_data_r, lo_data_r, q_s, r_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic               is_div_r, neg_q_r, neg_r_r;
    logic               busy_r, done_r, busy_s, done_s, load_s, accept_s;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .is_div  (is_div_r),
        .acc     (acc_r),
        .opnd    (opnd_r),
        .acc_nxt (acc_nxt_s)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_s  = state_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        load_s   = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && !cancel) begin
                    state_s  = S_CALC;
                    busy_s   = 1'b1;
                    accept_s = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            S_CALC: begin
                if (cancel) begin
                    state_s = S_IDLE;
                    busy_s  = 1'b0;
                end else if (cnt_r == ITER_LAST) begin
                    state_s = S_SIGN;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_SIGN: begin
                if (cancel) begin
                    state_s = S_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    state_s = S_DONE;
                    done_s  = 1'b1;
                    load_s  = 1'b1;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // FSM state and control output registers
    always_ff @(posedge MDU_clk or negedge MDU_rst_n) begin
        if (!MDU_rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Operand magnitudes for the unsigned core
    always_comb begin
        if (op_is_signed(op) && a[WIDTH-1]) begin
            a_mag_s = -a;
        end else begin
            a_mag_s = a;
        end
        if (op_is_signed(op) && b[WIDTH-1]) begin
            b_mag_s = -b;
        end else begin
            b_mag_s = b;
        end
    end

    // Signed fix-up; a zero divisor leaves the all-ones quotient un-negated
    always_comb begin
        q_s   = acc_r[WIDTH-1:0];
        r_s   = acc_r[2*WIDTH-1:WIDTH];
        res_s = acc_r;
        if (is_div_r) begin
            if (neg_q_r) begin
                q_s = -acc_r[WIDTH-1:0];
            end else begin
                q_s = acc_r[WIDTH-1:0];
            end
            if (neg_r_r) begin
                r_s = -acc_r[2*WIDTH-1:WIDTH];
            end else begin
                r_s = acc_r[2*WIDTH-1:WIDTH];
            end
            res_s = {r_s, q_s};
        end else if (neg_q_r) begin
            res_s = -acc_r;
        end else begin
            res_s = acc_r;
        end
    end

    // Operand capture, iteration state and HI/LO result registers
    always_ff @(posedge MDU_clk or negedge MDU_rst_n) begin
        if (!MDU_rst_n) begin
            cnt_r     <= 5'd0;
            acc_r     <= '0;
            opnd_r    <= '0;
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            hi_data_r <= '0;
            lo_data_r <= '0;
        end else begin
            if (accept_s) begin
                cnt_r    <= 5'd0;
                is_div_r <= op_is_div(op);
                acc_r    <= {{WIDTH{1'b0}}, (op_is_div(op) ? a_mag_s : b_mag_s)};
                opnd_r   <= op_is_div(op) ? b_mag_s : a_mag_s;
                neg_q_r  <= op_is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]) &&
                            !(op_is_div(op) && (b == '0));
                neg_r_r  <= op_is_signed(op) && op_is_div(op) && a[WIDTH-1];
            end else if (state_r == S_CALC) begin
                cnt_r <= cnt_r + 5'd1;
                acc_r <= acc_nxt_s;
            end
            if (load_s) begin
                hi_data_r <= res_s[2*WIDTH-1:WIDTH];
                lo_data_r <= res_s[WIDTH-1:0];
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign hi_w    = done_r;
    assign lo_w    = done_r;
    assign hi_data = hi_data_r;
    assign lo_data = lo_data_r;

endmodule
